ob_cntrl_mk_arb: RTL and testbench

Parametrised successor to the market-order trade decision logic in the order book controller. On a query, it snapshots the heads of the four order sources: limit bid, limit ask, market bid, market ask. It selects at most one trade using round-robin arbitration between the two limit-to-market pairings, then returns the result over a valid/ready handshake. It sits between the limit/market tables and the controller's trade-commit logic.

---
 rtl/ob_cntrl_mk_arb_if.sv | 32 +++
 rtl/ob_cntrl_mk_arb.sv | 93 +++++++++
 tb/tb_ob_cntrl_mk_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ob_cntrl_mk_arb_if.sv
// ob_cntrl_mk_arb_if: head-entry inputs, query handshake and trade response bundle for ob_cntrl_mk_arb
interface ob_cntrl_mk_arb_if #(
  parameter int QTY_W = 16,
  parameter int PRICE_W = 20,
  parameter int UID_W = 32,
  parameter int CNT_W = 16
);
  localparam int E_W = UID_W + PRICE_W + QTY_W;
  logic lm_bid_vld, lm_ask_vld, mk_bid_vld, mk_ask_vld;
  logic [E_W-1:0] lm_bid_e, lm_ask_e, mk_bid_e, mk_ask_e;
  logic trade_qry, qry_rdy, trade_vld, trade_rdy;
  logic [1:0] trade_kind;
  logic [UID_W-1:0] trade_ask_uid, trade_bid_uid;
  logic [PRICE_W-1:0] trade_price;
  logic [QTY_W-1:0] trade_qty, trade_rem;
  logic trade_ask_consumed, trade_bid_consumed;
  logic [CNT_W-1:0] trade_cnt;
  modport master (
    output lm_bid_vld, lm_ask_vld, mk_bid_vld, mk_ask_vld,
    output lm_bid_e, lm_ask_e, mk_bid_e, mk_ask_e,
    output trade_qry, trade_rdy,
    input qry_rdy, trade_vld, trade_kind, trade_ask_uid, trade_bid_uid,
    input trade_price, trade_qty, trade_rem, trade_ask_consumed, trade_bid_consumed, trade_cnt
  );
  modport slave (
    input lm_bid_vld, lm_ask_vld, mk_bid_vld, mk_ask_vld,
    input lm_bid_e, lm_ask_e, mk_bid_e, mk_ask_e,
    input trade_qry, trade_rdy,
    output qry_rdy, trade_vld, trade_kind, trade_ask_uid, trade_bid_uid,
    output trade_price, trade_qty, trade_rem, trade_ask_consumed, trade_bid_consumed, trade_cnt
  );
endinterface

// File: rtl/ob_cntrl_mk_arb.sv
// ob_cntrl_mk_arb: round-robin limit/market trade selector; OB_CNTRL_MK_MKMK_EN enables market-to-market trades
module ob_cntrl_mk_arb #(
  parameter int QTY_W = 16,
  parameter int PRICE_W = 20,
  parameter int UID_W = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  ob_cntrl_mk_arb_if.slave b
);
  localparam int E_W = UID_W + PRICE_W + QTY_W;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t st, st_n;
  logic [E_W-1:0] s_lb, s_la, s_ma;
  logic [UID_W-1:0] s_mb_uid;
  logic [QTY_W-1:0] s_mb_qty;
  logic [3:0] s_v;
  logic rr;
  logic lb, la, mb, ma, ca, cb, cc, ta, tb, tc, hit;
  logic [E_W-1:0] ask;
  logic [UID_W-1:0] bid_uid;
  logic [QTY_W-1:0] aq, bq;
  logic [PRICE_W-1:0] price;
  logic [QTY_W:0] d;
  logic [1:0] kind;
  always_comb begin
    lb = s_v[0] & (|s_lb[QTY_W-1:0]);
    la = s_v[1] & (|s_la[QTY_W-1:0]);
    mb = s_v[2] & (|s_mb_qty);
    ma = s_v[3] & (|s_ma[QTY_W-1:0]);
    ca = ma & lb;
    cb = la & mb;
`ifdef OB_CNTRL_MK_MKMK_EN
    cc = ma & mb;
`else
    cc = 1'b0;
`endif
    ta = ca & (~cb | ~rr);
    tb = cb & (~ca | rr);
    tc = cc & ~ca & ~cb;
    hit = ta | tb | tc;
    ask = tb ? s_la : s_ma;
    bid_uid = ta ? s_lb[E_W-1 -: UID_W] : s_mb_uid;
    aq = ask[QTY_W-1:0];
    bq = ta ? s_lb[QTY_W-1:0] : s_mb_qty;
    price = ta ? s_lb[QTY_W +: PRICE_W] : ask[QTY_W +: PRICE_W];
    d = {1'b0, aq} - {1'b0, bq};
    kind = ta ? 2'b01 : tb ? 2'b10 : tc ? 2'b11 : 2'b00;
    st_n = st == IDLE ? (b.trade_qry ? EVAL : IDLE) : st == EVAL ? RESP : (b.trade_rdy ? IDLE : RESP);
  end
  assign b.qry_rdy = st == IDLE;
  always_ff @(posedge clk)
    if (!rst) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk) begin
    if (st == IDLE && b.trade_qry) begin
      s_v <= {b.mk_ask_vld, b.mk_bid_vld, b.lm_ask_vld, b.lm_bid_vld};
      s_lb <= b.lm_bid_e;
      s_la <= b.lm_ask_e;
      s_ma <= b.mk_ask_e;
      s_mb_uid <= b.mk_bid_e[E_W-1 -: UID_W];
      s_mb_qty <= b.mk_bid_e[QTY_W-1:0];
    end
    if (!rst) begin
      rr <= 1'b0;
      b.trade_vld <= 1'b0;
      b.trade_kind <= '0;
      b.trade_ask_uid <= '0;
      b.trade_bid_uid <= '0;
      b.trade_price <= '0;
      b.trade_qty <= '0;
      b.trade_rem <= '0;
      b.trade_ask_consumed <= 1'b0;
      b.trade_bid_consumed <= 1'b0;
      b.trade_cnt <= '0;
    end else if (st == EVAL) begin
      rr <= rr ^ (ta | tb);
      b.trade_vld <= 1'b1;
      b.trade_kind <= kind;
      b.trade_ask_uid <= hit ? ask[E_W-1 -: UID_W] : '0;
      b.trade_bid_uid <= hit ? bid_uid : '0;
      b.trade_price <= hit ? price : '0;
      b.trade_qty <= hit ? (d[QTY_W] ? aq : bq) : '0;
      b.trade_rem <= hit ? (d[QTY_W] ? bq - aq : aq - bq) : '0;
      b.trade_ask_consumed <= hit & (d[QTY_W] | ~|d);
      b.trade_bid_consumed <= hit & ~d[QTY_W];
    end else if (st == RESP && b.trade_rdy) begin
      b.trade_vld <= 1'b0;
      if (|b.trade_kind && ~&b.trade_cnt) b.trade_cnt <= b.trade_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ob_cntrl_mk_arb.sv
// tb_ob_cntrl_mk_arb: table vectors, corner sequences and randomized queries against a behavioural trade model
module tb_ob_cntrl_mk_arb;
  typedef struct packed {logic v; logic [31:0] uid; logic [19:0] price; logic [15:0] qty;} src_t;
  typedef struct packed {logic [1:0] kind; logic [31:0] au; logic [31:0] bu; logic [19:0] price; logic [15:0] qty; logic [15:0] rem; logic ac; logic bc;} res_t;
  typedef struct packed {src_t [3:0] s; res_t e;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  ob_cntrl_mk_arb_if #(.CNT_W(2)) b();
  ob_cntrl_mk_arb #(.CNT_W(2)) dut (.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_chk = 0;
  src_t [3:0] cur;
  logic m_rr;
  int m_cnt;
  vec_t tv [8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a === x) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, x);
  endtask
  function automatic src_t mk(input logic v, input logic [31:0] u, input logic [19:0] p, input logic [15:0] q);
    return {v, u, p, q};
  endfunction
  function automatic res_t rs(input logic [1:0] k, input logic [31:0] au, input logic [31:0] bu, input logic [19:0] p,
                              input logic [15:0] q, input logic [15:0] r, input logic ac, input logic bc);
    return {k, au, bu, p, q, r, ac, bc};
  endfunction
  function automatic src_t rnd_src();
    logic [15:0] q;
    q = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'($urandom_range(0, 3));
    return mk($urandom_range(0, 3) != 0, $urandom, 20'($urandom), q);
  endfunction
  function automatic res_t model(input src_t [3:0] s, input logic rr);
    res_t r;
    logic pa, pb, pc;
    int k, ai, bi;
    logic [15:0] a, q;
    r = '0;
    pa = s[3].v && s[3].qty != 0 && s[0].v && s[0].qty != 0;
    pb = s[1].v && s[1].qty != 0 && s[2].v && s[2].qty != 0;
`ifdef OB_CNTRL_MK_MKMK_EN
    pc = s[3].v && s[3].qty != 0 && s[2].v && s[2].qty != 0;
`else
    pc = 1'b0;
`endif
    k = (pa && pb) ? (rr ? 2 : 1) : pa ? 1 : pb ? 2 : pc ? 3 : 0;
    if (k == 0) return r;
    ai = k == 2 ? 1 : 3;
    bi = k == 1 ? 0 : 2;
    a = s[ai].qty;
    q = s[bi].qty;
    r.kind = 2'(k);
    r.au = s[ai].uid;
    r.bu = s[bi].uid;
    r.price = k == 1 ? s[0].price : k == 2 ? s[1].price : s[3].price;
    r.qty = a < q ? a : q;
    r.rem = a > q ? a - q : q - a;
    r.ac = a <= q;
    r.bc = q <= a;
    return r;
  endfunction
  task automatic drive();
    b.lm_bid_vld = cur[0].v;
    b.lm_bid_e = {cur[0].uid, cur[0].price, cur[0].qty};
    b.lm_ask_vld = cur[1].v;
    b.lm_ask_e = {cur[1].uid, cur[1].price, cur[1].qty};
    b.mk_bid_vld = cur[2].v;
    b.mk_bid_e = {cur[2].uid, cur[2].price, cur[2].qty};
    b.mk_ask_vld = cur[3].v;
    b.mk_ask_e = {cur[3].uid, cur[3].price, cur[3].qty};
  endtask
  task automatic check_out(input string n, input res_t e);
    chk({n, ".kind"}, 64'(b.trade_kind), 64'(e.kind));
    chk({n, ".ask_uid"}, 64'(b.trade_ask_uid), 64'(e.au));
    chk({n, ".bid_uid"}, 64'(b.trade_bid_uid), 64'(e.bu));
    chk({n, ".price"}, 64'(b.trade_price), 64'(e.price));
    chk({n, ".qty"}, 64'(b.trade_qty), 64'(e.qty));
    chk({n, ".rem"}, 64'(b.trade_rem), 64'(e.rem));
    chk({n, ".ask_cons"}, 64'(b.trade_ask_consumed), 64'(e.ac));
    chk({n, ".bid_cons"}, 64'(b.trade_bid_consumed), 64'(e.bc));
  endtask
  task automatic do_reset();
    rst = 1'b0;
    b.trade_qry = 1'b0;
    b.trade_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_rr = 1'b0;
    m_cnt = 0;
    chk("rst.qry_rdy", 64'(b.qry_rdy), 64'd1);
    chk("rst.vld", 64'(b.trade_vld), 64'd0);
    chk("rst.cnt", 64'(b.trade_cnt), 64'd0);
    check_out("rst", '0);
  endtask
  task automatic do_query(input string n, input res_t e, input int hold);
    src_t [3:0] keep;
    keep = cur;
    drive();
    chk({n, ".qry_rdy"}, 64'(b.qry_rdy), 64'd1);
    b.trade_qry = 1'b1;
    tick();
    b.trade_qry = 1'b0;
    chk({n, ".lat_vld"}, 64'(b.trade_vld), 64'd0);
    tick();
    chk({n, ".vld"}, 64'(b.trade_vld), 64'd1);
    check_out(n, e);
    if (e.kind == 2'b01 || e.kind == 2'b10) m_rr = ~m_rr;
    for (int i = 0; i < hold; i++) begin
      for (int j = 0; j < 4; j++) cur[j] = rnd_src();
      drive();
      b.trade_qry = 1'($urandom);
      tick();
      chk({n, ".hold_vld"}, 64'(b.trade_vld), 64'd1);
      chk({n, ".hold_rdy"}, 64'(b.qry_rdy), 64'd0);
      check_out({n, ".hold"}, e);
    end
    b.trade_qry = 1'b0;
    b.trade_rdy = 1'b1;
    tick();
    b.trade_rdy = 1'b0;
    if (e.kind != 2'b00 && m_cnt != 3) m_cnt++;
    chk({n, ".done_vld"}, 64'(b.trade_vld), 64'd0);
    chk({n, ".cnt"}, 64'(b.trade_cnt), 64'(m_cnt));
    cur = keep;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tv[i] = '0;
    tv[0].s[0] = mk(1, 5, 100, 10);
    tv[0].s[3] = mk(1, 9, 0, 25);
    tv[0].e = rs(2'b01, 9, 5, 100, 10, 15, 0, 1);
    tv[1].s[0] = mk(1, 1, 200, 7);
    tv[1].s[1] = mk(1, 3, 300, 4);
    tv[1].s[2] = mk(1, 4, 0, 9);
    tv[1].s[3] = mk(1, 2, 0, 7);
    tv[1].e = rs(2'b10, 3, 4, 300, 4, 5, 1, 0);
    tv[2].s = tv[1].s;
    tv[2].e = rs(2'b01, 2, 1, 200, 7, 0, 1, 1);
    tv[3].s[0] = mk(1, 5, 100, 10);
    tv[3].s[3] = mk(1, 9, 50, 0);
    tv[4].s[2] = mk(1, 11, 66, 4);
    tv[4].s[3] = mk(1, 12, 555, 6);
`ifdef OB_CNTRL_MK_MKMK_EN
    tv[4].e = rs(2'b11, 12, 11, 555, 4, 2, 0, 1);
`endif
    for (int j = 0; j < 4; j++) tv[5].s[j] = mk(0, 32'(j + 40), 20'(j), 5);
    tv[6].s[1] = mk(1, 20, 77, 3);
    tv[6].s[2] = mk(1, 21, 0, 3);
    tv[6].s[0] = mk(1, 22, 88, 0);
    tv[6].e = rs(2'b10, 20, 21, 77, 3, 0, 1, 1);
    tv[7].s[0] = mk(1, 30, 1, 16'hFFFF);
    tv[7].s[3] = mk(1, 31, 2, 1);
    tv[7].e = rs(2'b01, 31, 30, 1, 1, 16'hFFFE, 1, 0);
    cur = '0;
    drive();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cur = tv[i].s;
      do_query($sformatf("vec%0d", i), tv[i].e, i % 3);
    end
    do_reset();
    cur = tv[1].s;
    for (int i = 0; i < 4; i++) do_query($sformatf("rr%0d", i), i % 2 ? tv[1].e : tv[2].e, 0);
    do_reset();
    cur = tv[0].s;
    do_query("bp", tv[0].e, 5);
    chk("bp.cnt1", 64'(b.trade_cnt), 64'd1);
    do_reset();
    cur = tv[4].s;
    do_query("mkmk", tv[4].e, 0);
    do_reset();
    cur = tv[0].s;
    do_query("pre", tv[0].e, 0);
    cur = tv[1].s;
    drive();
    b.trade_qry = 1'b1;
    tick();
    b.trade_qry = 1'b0;
    tick();
    chk("mid.vld", 64'(b.trade_vld), 64'd1);
    chk("mid.kind", 64'(b.trade_kind), 64'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_rr = 1'b0;
    m_cnt = 0;
    chk("mid.rst_vld", 64'(b.trade_vld), 64'd0);
    chk("mid.rst_cnt", 64'(b.trade_cnt), 64'd0);
    chk("mid.rst_rdy", 64'(b.qry_rdy), 64'd1);
    do_query("post", tv[2].e, 0);
    do_reset();
    cur = tv[0].s;
    for (int i = 0; i < 5; i++) do_query($sformatf("sat%0d", i), tv[0].e, 0);
    chk("sat.cnt", 64'(b.trade_cnt), 64'd3);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      for (int j = 0; j < 4; j++) cur[j] = rnd_src();
      do_query($sformatf("rnd%0d", i), model(cur, m_rr), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
